cl_pattern_gen: RTL and testbench

Synthesizable Camera Link test-pattern source. It generates fval/lval timing and multi-tap pixel data on the camera clock. Frame geometry, pattern mode and frame count are programmable at run time. It replaces hand-written stimulus loops: it feeds the cl receiver in simulation, and the FPGA loopback path in hardware when no camera is attached.

---
 rtl/cl_gen_pkg.sv | 22 ++
 rtl/cl_pattern_gen_data.sv | 42 ++++
 rtl/cl_pattern_gen.sv | 200 ++++++++++++++++++++
 tb/tb_cl_pattern_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_gen_pkg.sv
// Shared types and helpers for the Camera Link test-pattern source.
// State encoding, pattern mode codes and config clamping.
package cl_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LINE   = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_HRAMP = 2'd1;
  localparam logic [1:0] MODE_VRAMP = 2'd2;
  localparam logic [1:0] MODE_TAPID = 2'd3;

  // Geometry fields of zero would stall the timing chain.
  function automatic logic [31:0] clamp1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/cl_pattern_gen_data.sv
// Registered pixel formatter for the pattern source.
// Inputs describe the next cycle's pixel; data lands with lval.
module cl_pattern_data
  import cl_gen_pkg::*;
#(
  parameter int N_TAPS = 10,
  parameter int TAP_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic [CNT_W-1:0]        x,
  input  logic [CNT_W-1:0]        y,
  input  logic                    parity,
  input  logic [N_TAPS*TAP_W-1:0] cfg_const,
  input  logic                    valid,
  output logic [N_TAPS*TAP_W-1:0] data
);

  logic [N_TAPS-1:0][TAP_W-1:0] pix;

  always_comb begin
    pix = '0;
    for (int t = 0; t < N_TAPS; t++) begin
      unique case (mode)
        MODE_CONST: pix[t] = cfg_const[t*TAP_W +: TAP_W];
        MODE_HRAMP: pix[t] = TAP_W'(32'(x) * N_TAPS + t);
        MODE_VRAMP: pix[t] = TAP_W'(32'(y) + t);
        MODE_TAPID: pix[t] = TAP_W'(t) ^ {TAP_W{parity}};
        default:    pix[t] = '0;
      endcase
      if (!valid) pix[t] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) data <= '0;
    else       data <= pix;
  end

endmodule

// File: rtl/cl_pattern_gen.sv
// Camera Link fval/lval timing generator with multi-tap test patterns.
// Pixel coordinates are looked ahead one cycle for the data register.
module cl_pattern_gen
  import cl_gen_pkg::*;
#(
  parameter int N_TAPS = 10,
  parameter int TAP_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    cl_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CNT_W-1:0]        cfg_line_active,
  input  logic [CNT_W-1:0]        cfg_line_blank,
  input  logic [CNT_W-1:0]        cfg_lines,
  input  logic [CNT_W-1:0]        cfg_frame_blank,
  input  logic [CNT_W-1:0]        cfg_frames,
  input  logic [1:0]              cfg_mode,
  input  logic [N_TAPS*TAP_W-1:0] cfg_const,
  output logic                    cl_fval,
  output logic                    cl_lval,
  output logic [N_TAPS*TAP_W-1:0] cl_data,
  output logic                    busy,
  output logic                    frame_done,
  output logic [CNT_W-1:0]        frame_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] line;
  logic [CNT_W-1:0] act_q;
  logic [CNT_W-1:0] hb_q;
  logic [CNT_W-1:0] lines_q;
  logic [CNT_W-1:0] vb_q;
  logic [CNT_W-1:0] frames_q;
  logic [1:0]       mode_q;
  logic [N_TAPS*TAP_W-1:0] const_q;
  logic             stop_pend;

  logic last_act;
  logic last_hb;
  logic last_line;
  logic last_vb;
  logic halt;

  assign last_act  = (cnt == act_q - ONE);
  assign last_hb   = (cnt == hb_q - ONE);
  assign last_line = (line == lines_q - ONE);
  assign last_vb   = (cnt == vb_q - ONE);
  // A stop arriving on the final VBLANK clock still ends the run.
  assign halt = stop_pend | stop |
                ((frames_q != '0) && (frame_cnt == frames_q));

  logic                    nx_valid;
  logic [CNT_W-1:0]        nx_x;
  logic [CNT_W-1:0]        nx_y;
  logic                    nx_par;
  logic [1:0]              nx_mode;
  logic [N_TAPS*TAP_W-1:0] nx_const;

  always_comb begin
    nx_valid = 1'b0;
    nx_x     = '0;
    nx_y     = '0;
    nx_par   = frame_cnt[0];
    nx_mode  = mode_q;
    nx_const = const_q;
    unique case (state)
      IDLE: begin
        nx_valid = start;
        nx_par   = 1'b0;
        nx_mode  = cfg_mode;
        nx_const = cfg_const;
      end
      LINE: begin
        nx_valid = !last_act;
        nx_x     = cnt + ONE;
        nx_y     = line;
      end
      HBLANK: begin
        nx_valid = last_hb && !last_line;
        nx_y     = line + ONE;
      end
      VBLANK: begin
        nx_valid = last_vb && !halt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge cl_clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      line       <= '0;
      act_q      <= '0;
      hb_q       <= '0;
      lines_q    <= '0;
      vb_q       <= '0;
      frames_q   <= '0;
      mode_q     <= MODE_CONST;
      const_q    <= '0;
      stop_pend  <= 1'b0;
      cl_fval    <= 1'b0;
      cl_lval    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (stop && state != IDLE) stop_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            act_q     <= CNT_W'(clamp1(32'(cfg_line_active)));
            hb_q      <= CNT_W'(clamp1(32'(cfg_line_blank)));
            lines_q   <= CNT_W'(clamp1(32'(cfg_lines)));
            vb_q      <= CNT_W'(clamp1(32'(cfg_frame_blank)));
            frames_q  <= cfg_frames;
            mode_q    <= cfg_mode;
            const_q   <= cfg_const;
            frame_cnt <= '0;
            stop_pend <= 1'b0;
            cnt       <= '0;
            line      <= '0;
            state     <= LINE;
            cl_fval   <= 1'b1;
            cl_lval   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LINE: begin
          if (last_act) begin
            cnt     <= '0;
            state   <= HBLANK;
            cl_lval <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HBLANK: begin
          if (last_hb) begin
            cnt <= '0;
            if (last_line) begin
              state      <= VBLANK;
              cl_fval    <= 1'b0;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + ONE;
            end else begin
              state   <= LINE;
              line    <= line + ONE;
              cl_lval <= 1'b1;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        VBLANK: begin
          if (last_vb) begin
            cnt  <= '0;
            line <= '0;
            if (halt) begin
              state     <= IDLE;
              busy      <= 1'b0;
              stop_pend <= 1'b0;
            end else begin
              state   <= LINE;
              cl_fval <= 1'b1;
              cl_lval <= 1'b1;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cl_pattern_data #(
    .N_TAPS (N_TAPS),
    .TAP_W  (TAP_W),
    .CNT_W  (CNT_W)
  ) u_data (
    .clk       (cl_clk),
    .reset     (reset),
    .mode      (nx_mode),
    .x         (nx_x),
    .y         (nx_y),
    .parity    (nx_par),
    .cfg_const (nx_const),
    .valid     (nx_valid),
    .data      (cl_data)
  );

endmodule

// File: tb/tb_cl_pattern_gen.sv
// Testbench for cl_pattern_gen: per-cycle trace against a
// frame-geometry model computed from position within the frame.
module tb_cl_pattern_gen;

  localparam int N_TAPS = 10;
  localparam int TAP_W  = 8;
  localparam int CNT_W  = 16;
  localparam int DW     = N_TAPS * TAP_W;

  logic             cl_clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] cfg_line_active;
  logic [CNT_W-1:0] cfg_line_blank;
  logic [CNT_W-1:0] cfg_lines;
  logic [CNT_W-1:0] cfg_frame_blank;
  logic [CNT_W-1:0] cfg_frames;
  logic [1:0]       cfg_mode;
  logic [DW-1:0]    cfg_const;
  logic             cl_fval;
  logic             cl_lval;
  logic [DW-1:0]    cl_data;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;

  int checks = 0;
  int passes = 0;

  cl_pattern_gen #(
    .N_TAPS (N_TAPS),
    .TAP_W  (TAP_W),
    .CNT_W  (CNT_W)
  ) dut (
    .cl_clk          (cl_clk),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .cfg_line_active (cfg_line_active),
    .cfg_line_blank  (cfg_line_blank),
    .cfg_lines       (cfg_lines),
    .cfg_frame_blank (cfg_frame_blank),
    .cfg_frames      (cfg_frames),
    .cfg_mode        (cfg_mode),
    .cfg_const       (cfg_const),
    .cl_fval         (cl_fval),
    .cl_lval         (cl_lval),
    .cl_data         (cl_data),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_cnt       (frame_cnt)
  );

  always #5 cl_clk = ~cl_clk;

  function automatic logic [DW-1:0] model_data(
    input int mode, input int x, input int y,
    input int par, input logic [DW-1:0] k);
    logic [DW-1:0]    d;
    logic [TAP_W-1:0] v;
    d = '0;
    for (int t = 0; t < N_TAPS; t++) begin
      case (mode)
        0:       v = k[t*TAP_W +: TAP_W];
        1:       v = TAP_W'(x * N_TAPS + t);
        2:       v = TAP_W'(y + t);
        default: v = TAP_W'(t) ^ ((par % 2 == 1) ? {TAP_W{1'b1}} : '0);
      endcase
      d[t*TAP_W +: TAP_W] = v;
    end
    return d;
  endfunction

  task automatic drive_cfg(input int a, input int b, input int l,
                           input int fb, input int frames,
                           input int mode, input logic [DW-1:0] k);
    cfg_line_active = CNT_W'(a);
    cfg_line_blank  = CNT_W'(b);
    cfg_lines       = CNT_W'(l);
    cfg_frame_blank = CNT_W'(fb);
    cfg_frames      = CNT_W'(frames);
    cfg_mode        = 2'(mode);
    cfg_const       = k;
  endtask

  // Start one run and compare every cycle until one cycle after it ends.
  task automatic run_frames(
    input string name, input int a, input int b, input int l,
    input int fb, input int frames, input int mode,
    input logic [DW-1:0] k, input int stop_at, input int restart_at,
    input bit stop_with_start);
    int A, B, L, FB, LP, FH, P, nf, ns, total;
    int f, r, y, c;
    logic efval, elval, ebusy, edone;
    logic [CNT_W-1:0] ecnt;
    logic [DW-1:0] edata;
    A  = (a == 0) ? 1 : a;
    B  = (b == 0) ? 1 : b;
    L  = (l == 0) ? 1 : l;
    FB = (fb == 0) ? 1 : fb;
    LP = A + B;
    FH = L * LP;
    P  = FH + FB;
    ns = (stop_at > 0) ? (stop_at + P - 1) / P : 0;
    if (frames == 0)                 nf = ns;
    else if (stop_at > 0 && ns < frames) nf = ns;
    else                             nf = frames;
    total = nf * P;
    drive_cfg(a, b, l, fb, frames, mode, k);
    start = 1'b1;
    stop  = stop_with_start;
    for (int i = 0; i <= total; i++) begin
      @(posedge cl_clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      cfg_line_active = CNT_W'($urandom);
      cfg_line_blank  = CNT_W'($urandom);
      cfg_lines       = CNT_W'($urandom);
      cfg_frame_blank = CNT_W'($urandom);
      cfg_frames      = CNT_W'($urandom);
      cfg_mode        = 2'($urandom);
      cfg_const       = DW'({$urandom(), $urandom(), $urandom()});
      if (i < total) begin
        f = i / P;
        r = i % P;
        y = r / LP;
        c = r % LP;
        efval = (r < FH);
        elval = efval && (c < A);
        ebusy = 1'b1;
        edone = (r == FH);
        ecnt  = CNT_W'(f + ((r >= FH) ? 1 : 0));
        edata = elval ? model_data(mode, c, y, f, k) : '0;
      end else begin
        efval = 1'b0;
        elval = 1'b0;
        ebusy = 1'b0;
        edone = 1'b0;
        ecnt  = CNT_W'(nf);
        edata = '0;
      end
      checks++;
      if ({cl_fval, cl_lval, busy, frame_done, frame_cnt, cl_data} !==
          {efval, elval, ebusy, edone, ecnt, edata})
        $display("FAIL %s cyc %0d: fval/lval/busy/done=%b%b%b%b cnt=%0d data=%h, required %b%b%b%b cnt=%0d data=%h",
                 name, i, cl_fval, cl_lval, busy, frame_done, frame_cnt,
                 cl_data, efval, elval, ebusy, edone, ecnt, edata);
      else
        passes++;
      if (i + 1 == stop_at)    stop  = 1'b1;
      if (i + 1 == restart_at) start = 1'b1;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0, '0);
    repeat (3) @(posedge cl_clk);
    #1;
    checks++;
    if ({cl_fval, cl_lval, busy, frame_done, frame_cnt, cl_data} !== '0)
      $display("FAIL reset: fval/lval/busy/done=%b%b%b%b cnt=%0d data=%h, required all zero",
               cl_fval, cl_lval, busy, frame_done, frame_cnt, cl_data);
    else
      passes++;
    reset = 1'b0;
    @(posedge cl_clk);
    #1;
  endtask

  task automatic test_const;
    logic [DW-1:0] k;
    k = 80'h07_01_06_09_1F_1E_1D_1C_1B_1A;
    run_frames("const", 8, 2, 9, 10, 2, 0, k, 0, 45, 1'b0);
  endtask

  task automatic test_hramp;
    run_frames("hramp", 4, 2, 1, 3, 1, 1, '0, 0, 0, 1'b0);
  endtask

  task automatic test_vramp;
    run_frames("vramp", 2, 1, 3, 2, 2, 2, '0, 0, 0, 1'b0);
  endtask

  task automatic test_stop_freerun;
    run_frames("stop_free", 8, 2, 4, 5, 0, 3, '0, 2 * 45 + 35, 0, 1'b0);
  endtask

  task automatic test_zero_geom;
    run_frames("zero_geom", 0, 0, 0, 0, 2, 1, '0, 0, 0, 1'b0);
  endtask

  task automatic test_start_stop_same;
    run_frames("start_stop", 3, 1, 2, 2, 2, 3, '0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid;
    drive_cfg(3, 1, 1, 2, 0, 3, '0);
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge cl_clk);
      #1;
      start = 1'b0;
    end
    checks++;
    if ({cl_fval, cl_lval, busy, frame_cnt} !== {1'b1, 1'b1, 1'b1, CNT_W'(1)})
      $display("FAIL reset_mid_pre: fval/lval/busy=%b%b%b cnt=%0d, required 111 cnt=1",
               cl_fval, cl_lval, busy, frame_cnt);
    else
      passes++;
    reset = 1'b1;
    @(posedge cl_clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({cl_fval, cl_lval, busy, frame_done, frame_cnt, cl_data} !== '0)
      $display("FAIL reset_mid: fval/lval/busy/done=%b%b%b%b cnt=%0d data=%h, required all zero",
               cl_fval, cl_lval, busy, frame_done, frame_cnt, cl_data);
    else
      passes++;
    repeat (6) @(posedge cl_clk);
    #1;
    checks++;
    if ({cl_fval, cl_lval, busy, cl_data} !== '0)
      $display("FAIL reset_mid_idle: fval/lval/busy=%b%b%b data=%h, required idle",
               cl_fval, cl_lval, busy, cl_data);
    else
      passes++;
  endtask

  task automatic test_random;
    int a, b, l, fb, frames, mode, P, s;
    logic [DW-1:0] k;
    for (int n = 0; n < 6; n++) begin
      a      = $urandom_range(1, 6);
      b      = $urandom_range(1, 4);
      l      = $urandom_range(1, 4);
      fb     = $urandom_range(1, 5);
      frames = $urandom_range(0, 3);
      mode   = $urandom_range(0, 3);
      k      = DW'({$urandom(), $urandom(), $urandom()});
      P      = l * (a + b) + fb;
      s      = (frames == 0 || n % 2 == 1) ? $urandom_range(1, 3 * P) : 0;
      run_frames("random", a, b, l, fb, frames, mode, k, s, 0, 1'b0);
      repeat (2) @(posedge cl_clk);
      #1;
    end
  endtask

  initial begin
    test_reset;
    test_const;
    test_hramp;
    test_vramp;
    test_stop_freerun;
    test_zero_geom;
    test_start_stop_same;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
